// File: rtl/eight_dot_product_multiply_pkg.sv
// Purpose: shared constants and helpers for the eight-lane dot-product multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package eight_dot_product_multiply_pkg;

    // Default element/result width and number of parallel lanes per beat.
    localparam int ELEM_W = 32;
    localparam int LANES  = 8;

    // Number of 8-lane beats needed to cover a vector of noe elements.
    function automatic int calc_chunks(input int noe);
        return (noe + LANES - 1) / LANES;
    endfunction

endpackage

// File: rtl/eight_dot_product_multiply_dot8_lane_reduce.sv
// Purpose: eight signed lane products reduced through an 8->4->2->1 adder tree.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module dot8_lane_reduce
    import eight_dot_product_multiply_pkg::LANES;
#(
    parameter int ELEM_W = 32
) (
    input  logic [LANES*ELEM_W-1:0] a_i,
    input  logic [LANES*ELEM_W-1:0] b_i,
    output logic [ELEM_W-1:0]       sum_o
);

    logic signed [ELEM_W-1:0] prod [LANES];
    logic signed [ELEM_W-1:0] lvl1 [LANES/2];
    logic signed [ELEM_W-1:0] lvl2 [LANES/4];

    // Lane products, wrapped to ELEM_W bits (low bits are sign-agnostic).
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i] = $signed(a_i[ELEM_W*i +: ELEM_W]) * $signed(b_i[ELEM_W*i +: ELEM_W]);
        end
    end

    // Pairwise reduction tree; every sum wraps modulo 2^ELEM_W.
    always_comb begin
        for (int j = 0; j < LANES/2; j++) begin
            lvl1[j] = prod[2*j] + prod[2*j+1];
        end
        for (int j = 0; j < LANES/4; j++) begin
            lvl2[j] = lvl1[2*j] + lvl1[2*j+1];
        end
        sum_o = lvl2[0] + lvl2[1];
    end

endmodule

// File: rtl/eight_dot_product_multiply.sv
// Purpose: NOE-element signed dot product, fed 8 lanes per beat every other cycle.
// Latency: finish/result registered at edge 2*CHUNKS+2 after reset release.
// Backpressure: none; producer must present beat k around edge 2k+3, result then held until reset.
module eight_dot_product_multiply
    import eight_dot_product_multiply_pkg::LANES;
    import eight_dot_product_multiply_pkg::calc_chunks;
#(
    parameter int NOE    = 16,
    parameter int ELEM_W = eight_dot_product_multiply_pkg::ELEM_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES*ELEM_W-1:0] first_row_input,
    input  logic [LANES*ELEM_W-1:0] second_row_input,
    output logic [ELEM_W-1:0]       result,
    output logic                    finish
);

    localparam int CHUNKS    = calc_chunks(NOE);
    localparam int LAST_EDGE = 2*CHUNKS + 2;
    localparam int CW        = $clog2(LAST_EDGE + 1);

    // cnt_q holds the number of edges seen since reset release, so the edge
    // about to happen is cnt_q+1. Beat k is sampled when cnt_q == 2k+2,
    // accumulated when cnt_q == 2k+3, and the last accumulate coincides with
    // loading the result.
    localparam logic [CW-1:0] SAMPLE_LO = CW'(2);
    localparam logic [CW-1:0] SAMPLE_HI = CW'(2*CHUNKS);
    localparam logic [CW-1:0] ACC_LO    = CW'(3);
    localparam logic [CW-1:0] FINAL_CNT = CW'(2*CHUNKS + 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ELEM_W-1:0] beat_sum_q, beat_sum_d;
    logic [ELEM_W-1:0] acc_q, acc_d;
    logic [ELEM_W-1:0] result_q, result_d;
    logic              finish_q, finish_d;
    logic [ELEM_W-1:0] tree_sum;

    dot8_lane_reduce #(
        .ELEM_W (ELEM_W)
    ) u_reduce (
        .a_i   (first_row_input),
        .b_i   (second_row_input),
        .sum_o (tree_sum)
    );

    // Edge schedule: sample on odd edges, accumulate on the following even edge, freeze on finish.
    always_comb begin
        cnt_d      = cnt_q;
        beat_sum_d = beat_sum_q;
        acc_d      = acc_q;
        result_d   = result_q;
        finish_d   = finish_q;
        if (!finish_q) begin
            cnt_d = cnt_q + CW'(1);
            if (!cnt_q[0] && cnt_q >= SAMPLE_LO && cnt_q <= SAMPLE_HI) begin
                beat_sum_d = tree_sum;
            end
            if (cnt_q[0] && cnt_q >= ACC_LO && cnt_q <= FINAL_CNT) begin
                acc_d = acc_q + beat_sum_q;
            end
            if (cnt_q == FINAL_CNT) begin
                result_d = acc_q + beat_sum_q;
                finish_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial sum and restarts edge counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            beat_sum_q <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            finish_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            beat_sum_q <= beat_sum_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            finish_q   <= finish_d;
        end
    end

    assign result = result_q;
    assign finish = finish_q;

endmodule

// File: tb/tb_eight_dot_product_multiply.sv
module tb_eight_dot_product_multiply;

    localparam int NBEATS  = 3;
    localparam int NEDGES  = 18;
    localparam int NVEC    = 5;

    typedef struct packed {
        logic [NBEATS-1:0][255:0] a;
        logic [NBEATS-1:0][255:0] b;
        logic [31:0]              exp16;
        logic [31:0]              exp20;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [255:0] row_a;
    logic [255:0] row_b;
    logic [31:0]  res16, res20;
    logic         fin16, fin20;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tbl [NVEC];

    eight_dot_product_multiply #(.NOE(16), .ELEM_W(32)) dut16 (
        .clk              (clk),
        .reset            (reset),
        .first_row_input  (row_a),
        .second_row_input (row_b),
        .result           (res16),
        .finish           (fin16)
    );

    eight_dot_product_multiply #(.NOE(20), .ELEM_W(32)) dut20 (
        .clk              (clk),
        .reset            (reset),
        .first_row_input  (row_a),
        .second_row_input (row_b),
        .result           (res20),
        .finish           (fin20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rep(input int v);
        logic [31:0] w;
        w = v;
        return {8{w}};
    endfunction

    function automatic logic [255:0] rnd_beat();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Reference: sum over the first nchunks beats of lane-wise signed products, 32-bit wrap.
    function automatic logic [31:0] model(input logic [NBEATS-1:0][255:0] a,
                                          input logic [NBEATS-1:0][255:0] b,
                                          input int nchunks);
        int s;
        int x;
        int y;
        s = 0;
        for (int k = 0; k < nchunks; k++) begin
            for (int l = 0; l < 8; l++) begin
                x = a[k][32*l +: 32];
                y = b[k][32*l +: 32];
                s = s + x * y;
            end
        end
        return s;
    endfunction

    // One transaction from reset; abort_edge > 0 asserts reset right after that edge.
    task automatic run(input string tag, input vec_t v, input int abort_edge);
        logic exp_f16, exp_f20;
        reset = 1'b0;
        row_a = rnd_beat();
        row_b = rnd_beat();
        repeat (2) @(negedge clk);
        chk({tag, " rst res16"}, res16, 32'd0);
        chk({tag, " rst fin16"}, {31'd0, fin16}, 32'd0);
        chk({tag, " rst res20"}, res20, 32'd0);
        chk({tag, " rst fin20"}, {31'd0, fin20}, 32'd0);
        reset = 1'b1;
        for (int n = 1; n <= NEDGES; n++) begin
            if ((n % 2 == 1) && n >= 3 && ((n - 3) / 2) < NBEATS) begin
                row_a = v.a[(n - 3) / 2];
                row_b = v.b[(n - 3) / 2];
            end else begin
                row_a = rnd_beat();
                row_b = rnd_beat();
            end
            @(posedge clk);
            #1;
            exp_f16 = (n >= 6);
            exp_f20 = (n >= 8);
            chk($sformatf("%s e%0d fin16", tag, n), {31'd0, fin16}, {31'd0, exp_f16});
            chk($sformatf("%s e%0d res16", tag, n), res16, exp_f16 ? v.exp16 : 32'd0);
            chk($sformatf("%s e%0d fin20", tag, n), {31'd0, fin20}, {31'd0, exp_f20});
            chk($sformatf("%s e%0d res20", tag, n), res20, exp_f20 ? v.exp20 : 32'd0);
            if (n == abort_edge) begin
                reset = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    #1;
                    chk($sformatf("%s midrst%0d fin16", tag, c), {31'd0, fin16}, 32'd0);
                    chk($sformatf("%s midrst%0d res16", tag, c), res16, 32'd0);
                    @(posedge clk);
                end
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t rv;
        logic [255:0] ramp;
        reset = 1'b0;
        row_a = '0;
        row_b = '0;

        for (int i = 0; i < 8; i++) ramp[32*i +: 32] = i + 1;

        // All ones, every beat.
        tbl[0].a = {rep(1), rep(1), rep(1)};
        tbl[0].b = {rep(1), rep(1), rep(1)};
        tbl[0].exp16 = 32'd16;
        tbl[0].exp20 = 32'd24;
        // Ramp 1..8 times 2 for two beats, third beat zero.
        tbl[1].a = {256'd0, ramp, ramp};
        tbl[1].b = {256'd0, rep(2), rep(2)};
        tbl[1].exp16 = 32'd144;
        tbl[1].exp20 = 32'd144;
        // Negative operands.
        tbl[2].a = {rep(-3), rep(-3), rep(-3)};
        tbl[2].b = {rep(5), rep(5), rep(5)};
        tbl[2].exp16 = 32'hFFFF_FF10;
        tbl[2].exp20 = 32'hFFFF_FE98;
        // 2^16 * 2^16 wraps to zero.
        tbl[3].a = {256'd0, 256'd0, {224'd0, 32'h0001_0000}};
        tbl[3].b = {256'd0, 256'd0, {224'd0, 32'h0001_0000}};
        tbl[3].exp16 = 32'd0;
        tbl[3].exp20 = 32'd0;
        // Only the third beat is non-zero: lane3 7*9.
        tbl[4].a = {{128'd0, 32'd7, 96'd0}, 256'd0, 256'd0};
        tbl[4].b = {{128'd0, 32'd9, 96'd0}, 256'd0, 256'd0};
        tbl[4].exp16 = 32'd0;
        tbl[4].exp20 = 32'd63;

        for (int i = 0; i < NVEC; i++) begin
            run($sformatf("vec%0d", i), tbl[i], 0);
        end

        // Reset mid-operation at edge 5, then a clean rerun.
        run("abort", tbl[0], 5);
        run("rerun", tbl[0], 0);

        // Random operands against the reference model.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NBEATS; k++) begin
                rv.a[k] = rnd_beat();
                rv.b[k] = rnd_beat();
                if (r % 2 == 1) begin
                    for (int l = 0; l < 8; l++) begin
                        rv.a[k][32*l +: 32] = $urandom_range(0, 200) - 100;
                        rv.b[k][32*l +: 32] = $urandom_range(0, 200) - 100;
                    end
                end
            end
            rv.exp16 = model(rv.a, rv.b, 2);
            rv.exp20 = model(rv.a, rv.b, 3);
            run($sformatf("rnd%0d", r), rv, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eight_dot_product_multiply.md
EIGHT_DOT_PRODUCT_MULTIPLY -- requirements
Module: eight_dot_product_multiply

Interface
REQ-001 SHALL have parameter NOE, default 16, meaning total vector length; CHUNKS = ceil(NOE/8) beats per dot product.
REQ-002 SHALL have parameter ELEM_W, default 32, meaning element and result width.
REQ-003 SHALL have port clk, input, 1 bit; single clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-low (0 = in reset).
REQ-005 SHALL have port first_row_input, input, 8*ELEM_W bits; lane i = bits [ELEM_W*i+ELEM_W-1 : ELEM_W*i], i=0..7.
REQ-006 SHALL have port second_row_input, input, 8*ELEM_W bits; same lane packing.
REQ-007 SHALL have port result, output, ELEM_W bits; final dot product, registered.
REQ-008 SHALL have port finish, output, 1 bit; high when result is valid, registered.

Function
REQ-009 SHALL treat all elements as signed two's-complement; products and sums truncated to ELEM_W bits (wrap modulo 2^ELEM_W, no saturation).
REQ-010 SHALL count rising edges after reset release: edge 1 is the first rising edge with reset=1.
REQ-011 SHALL sample beat k (k=0..CHUNKS-1) at edge 2k+3; inputs need only be stable around odd edges, since the producer updates every other cycle.
REQ-012 At each sample edge, SHALL form the 8 lane products, reduce them with an 8->4->2->1 adder tree and register the sum in a beat-sum register.
REQ-013 At the edge following each sample edge (edge 2k+4), SHALL add the beat-sum register into the accumulator.
REQ-014 At edge 2*CHUNKS+2, SHALL load result with the final accumulator value and set finish=1.
REQ-015 After finish rises, SHALL hold result and finish constant, ignore inputs, and perform no further accumulation until reset.
REQ-016 Before finish, result SHALL read 0.
REQ-017 With NOE not a multiple of 8, the last beat SHALL still use all 8 lanes; the caller zero-pads unused lanes.

Reset
REQ-018 reset=0 SHALL asynchronously clear the edge counter, beat-sum register, accumulator, result (0) and finish (0).
REQ-019 Reset asserted mid-operation SHALL discard partial sums; after release, edge counting restarts at edge 1.

Structure
REQ-020 ELEM_W=32 and LANES=8 SHALL live in a shared package, with a function computing CHUNKS from NOE.
REQ-021 The 8-input multiply/adder-tree reduction SHALL be one sub-module, dot8_lane_reduce, combinational, instantiated once.
REQ-022 The control counter and accumulator SHALL reside in the top module; no other sub-modules.

Verification
REQ-023 NOE=16, all lanes 1 on both rows for both beats -> finish rises at edge 6, result=16.
REQ-024 NOE=16, row1 lanes = 1..8 (lane0=1), row2 all 2, both beats -> result=144 at edge 6.
REQ-025 NOE=16, row1 all -3, row2 all 5 -> result=-240 (0xFFFFFF10).
REQ-026 NOE=16, lane0 = 0x00010000 on both rows, beat 0 only, other lanes and beat 1 zero -> result=0 (wrap).
REQ-027 NOE=20 (CHUNKS=3), all lanes 1 -> finish at edge 8, result=24; finish and result held for 10 more cycles.
REQ-028 Assert reset at edge 5, release, re-run the REQ-023 stimulus -> result=16 at edge 6 of the new run, finish=0 throughout the reset.
